// File: rtl/usbdev_linestate_mon.sv
// ============================================================================
//  Module      : usbdev_linestate_mon
//  Description : USB device receive-side front end. Synchronises the raw pad
//                inputs, glitch-filters dp/dn/d, classifies the bus line
//                state and detects bus reset, suspend and resume. Debounces
//                VBUS sense with a register override.
//                Optional sticky SE1 error flag, enabled by defining
//                USBDEV_LINESTATE_SE1_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usbdev_linestate_mon #(
  parameter int SyncStages    = 2,
  parameter int FilterLen     = 3,
  parameter int ResetCycles   = 120,
  parameter int SuspendCycles = 144000,
  parameter int SenseDebounce = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       rx_diff_mode_i,
  input  logic       tx_oe_i,
  input  logic       sense_ovr_en_i,
  input  logic       sense_ovr_val_i,
  input  logic       cio_dp_i,
  input  logic       cio_dn_i,
  input  logic       cio_d_i,
  input  logic       cio_sense_i,
  output logic       rx_d_o,
  output logic       rx_se0_o,
  output logic [1:0] line_state_o,
  output logic       bus_reset_o,
  output logic       suspend_o,
  output logic       resume_o,
  output logic       sense_o,
  output logic       se1_err_o
);

  localparam int c_RUN_W  = $clog2(FilterLen + 1);
  localparam int c_SE0_W  = $clog2(ResetCycles + 1);
  localparam int c_IDLE_W = $clog2(SuspendCycles + 1);
  localparam int c_SNS_W  = $clog2(SenseDebounce + 1);

  localparam logic [c_RUN_W-1:0]  c_RUN_MAX  = c_RUN_W'(FilterLen);
  localparam logic [c_SE0_W-1:0]  c_SE0_MAX  = c_SE0_W'(ResetCycles);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(SuspendCycles);
  localparam logic [c_SNS_W-1:0]  c_SNS_MAX  = c_SNS_W'(SenseDebounce);

  // Filter channel order {d, dn, dp}; idle bus is J with d=1.
  localparam logic [2:0] c_CH_RST = 3'b101;

  localparam logic [1:0] c_LS_SE0 = 2'd0;
  localparam logic [1:0] c_LS_J   = 2'd1;
  localparam logic [1:0] c_LS_K   = 2'd2;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_RESET   = 2'd1,
    ST_SUSPEND = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Synchronisers
  // --------------------------------------------------------------------------
  logic [SyncStages-1:0] r_sync_dp;
  logic [SyncStages-1:0] r_sync_dn;
  logic [SyncStages-1:0] r_sync_d;
  logic [SyncStages-1:0] r_sync_sense;
  logic [2:0]            w_sync;

  // Multi-flop synchronisers, reset to the idle-J pattern.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync_dp    <= '1;
      r_sync_dn    <= '0;
      r_sync_d     <= '1;
      r_sync_sense <= '0;
    end else begin
      r_sync_dp    <= {r_sync_dp[SyncStages-2:0],    cio_dp_i};
      r_sync_dn    <= {r_sync_dn[SyncStages-2:0],    cio_dn_i};
      r_sync_d     <= {r_sync_d[SyncStages-2:0],     cio_d_i};
      r_sync_sense <= {r_sync_sense[SyncStages-2:0], cio_sense_i};
    end
  end

  assign w_sync = {r_sync_d[SyncStages-1], r_sync_dn[SyncStages-1], r_sync_dp[SyncStages-1]};

  // --------------------------------------------------------------------------
  // Glitch filters. w_filt_nxt is the value the filter takes on this edge so
  // the registered outputs below see a change in the same cycle as the
  // filter, giving a pad-to-output latency of SyncStages+FilterLen.
  // --------------------------------------------------------------------------
  logic [2:0] w_filt_nxt;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    logic               r_filt;
    logic               r_cand;
    logic [c_RUN_W-1:0] r_run;
    logic               w_diff;
    logic [c_RUN_W-1:0] w_step;
    logic               w_take;

    assign w_diff = w_sync[i] ^ r_filt;
    assign w_step = ((r_run != '0) && (r_cand == w_sync[i])) ? r_run + c_RUN_W'(1)
                                                             : c_RUN_W'(1);
    assign w_take = w_diff && (w_step == c_RUN_MAX);
    assign w_filt_nxt[i] = w_take ? w_sync[i] : r_filt;

    // Run-length filter: adopt the synced value once it has differed from
    // the filtered value for FilterLen consecutive samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_filt <= c_CH_RST[i];
        r_cand <= c_CH_RST[i];
        r_run  <= '0;
      end else if (!w_diff) begin
        r_cand <= r_filt;
        r_run  <= '0;
      end else if (w_take) begin
        r_filt <= w_sync[i];
        r_run  <= '0;
      end else begin
        r_cand <= w_sync[i];
        r_run  <= w_step;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered line-state outputs
  // --------------------------------------------------------------------------
  logic       r_rx_d;
  logic       r_rx_se0;
  logic [1:0] r_line_state;

  // Classify the filtered bus and select the receive data source.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_d       <= 1'b1;
      r_rx_se0     <= 1'b0;
      r_line_state <= c_LS_J;
    end else begin
      r_line_state <= {w_filt_nxt[1], w_filt_nxt[0]};
      r_rx_se0     <= ~(w_filt_nxt[1] | w_filt_nxt[0]);
      r_rx_d       <= rx_diff_mode_i ? w_filt_nxt[2] : w_filt_nxt[0];
    end
  end

  logic w_is_se0;
  logic w_is_j;
  logic w_is_k;

  assign w_is_se0 = (r_line_state == c_LS_SE0);
  assign w_is_j   = (r_line_state == c_LS_J);
  assign w_is_k   = (r_line_state == c_LS_K);

  // --------------------------------------------------------------------------
  // SE0 and idle counters (saturating). SE1 and K fall through to clear.
  // --------------------------------------------------------------------------
  logic [c_SE0_W-1:0]  r_se0_cnt;
  logic [c_SE0_W-1:0]  w_se0_cnt_nxt;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [c_IDLE_W-1:0] w_idle_cnt_nxt;

  // Next counter values: clear on any break in the condition, else saturate.
  always_comb begin
    w_se0_cnt_nxt  = r_se0_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    if (!enable_i || tx_oe_i || !w_is_se0) begin
      w_se0_cnt_nxt = '0;
    end else if (r_se0_cnt != c_SE0_MAX) begin
      w_se0_cnt_nxt = r_se0_cnt + c_SE0_W'(1);
    end
    if (!enable_i || tx_oe_i || !w_is_j) begin
      w_idle_cnt_nxt = '0;
    end else if (r_idle_cnt != c_IDLE_MAX) begin
      w_idle_cnt_nxt = r_idle_cnt + c_IDLE_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_se0_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_se0_cnt  <= w_se0_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Bus state machine
  // --------------------------------------------------------------------------
  state_e r_state;
  state_e w_state_nxt;
  logic   w_bus_reset_nxt;
  logic   w_resume_nxt;
  logic   r_bus_reset;
  logic   r_resume;
  logic   w_reset_hit;
  logic   w_susp_hit;

  assign w_reset_hit = (w_se0_cnt_nxt == c_SE0_MAX);
  assign w_susp_hit  = (w_idle_cnt_nxt == c_IDLE_MAX);

  // Next state and pulse decode; reset detection takes priority over suspend.
  always_comb begin
    w_state_nxt     = r_state;
    w_bus_reset_nxt = 1'b0;
    w_resume_nxt    = 1'b0;
    if (!enable_i) begin
      w_state_nxt = ST_ACTIVE;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_reset_hit) begin
            w_state_nxt     = ST_RESET;
            w_bus_reset_nxt = 1'b1;
          end else if (w_susp_hit) begin
            w_state_nxt = ST_SUSPEND;
          end
        end
        ST_RESET: begin
          if (!w_is_se0) begin
            w_state_nxt = ST_ACTIVE;
          end
        end
        ST_SUSPEND: begin
          if (w_reset_hit) begin
            w_state_nxt     = ST_RESET;
            w_bus_reset_nxt = 1'b1;
          end else if (w_is_k) begin
            w_state_nxt  = ST_ACTIVE;
            w_resume_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ACTIVE;
        end
      endcase
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_ACTIVE;
      r_bus_reset <= 1'b0;
      r_resume    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_reset <= w_bus_reset_nxt;
      r_resume    <= w_resume_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // VBUS sense debounce. The override skips the synchroniser only.
  // --------------------------------------------------------------------------
  logic               w_sense_src;
  logic               r_sense;
  logic [c_SNS_W-1:0] r_sns_cnt;
  logic [c_SNS_W-1:0] w_sns_step;

  assign w_sense_src = sense_ovr_en_i ? sense_ovr_val_i : r_sync_sense[SyncStages-1];
  assign w_sns_step  = r_sns_cnt + c_SNS_W'(1);

  // Follow the source once it has differed for SenseDebounce straight cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sense   <= 1'b0;
      r_sns_cnt <= '0;
    end else if (w_sense_src == r_sense) begin
      r_sns_cnt <= '0;
    end else if (w_sns_step == c_SNS_MAX) begin
      r_sense   <= w_sense_src;
      r_sns_cnt <= '0;
    end else begin
      r_sns_cnt <= w_sns_step;
    end
  end

  // --------------------------------------------------------------------------
  // Optional sticky SE1 error
  // --------------------------------------------------------------------------
`ifdef USBDEV_LINESTATE_SE1_ERR_EN
  logic w_is_se1;
  logic r_se1_seen;
  logic r_se1_err;

  assign w_is_se1 = (r_line_state == 2'd3);

  // Flag SE1 seen on two consecutive filtered cycles; cleared only by disable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_se1_seen <= 1'b0;
      r_se1_err  <= 1'b0;
    end else if (!enable_i) begin
      r_se1_seen <= 1'b0;
      r_se1_err  <= 1'b0;
    end else begin
      r_se1_seen <= w_is_se1;
      if (w_is_se1 && r_se1_seen) begin
        r_se1_err <= 1'b1;
      end
    end
  end

  assign se1_err_o = r_se1_err;
`else
  assign se1_err_o = 1'b0;
`endif

  assign rx_d_o       = r_rx_d;
  assign rx_se0_o     = r_rx_se0;
  assign line_state_o = r_line_state;
  assign bus_reset_o  = r_bus_reset;
  assign resume_o     = r_resume;
  assign suspend_o    = (r_state == ST_SUSPEND);
  assign sense_o      = r_sense;

endmodule

`default_nettype wire
